// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DEFAULT_N = 32;
  localparam int DEFAULT_M = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Replicated to the quotient width to form the all-ones divide-by-zero quotient.
  localparam logic DIV0_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int M = DEFAULT_M
) (
  input  logic [M:0]   part_rem,
  input  logic         next_bit,
  input  logic [M-1:0] divisor_mag,
  output logic [M:0]   next_rem,
  output logic         q_bit
);

  logic [M+1:0] shifted;
  logic [M:0]   diff;

  // The partial remainder is always below the divisor, so the shifted value fits M+1 bits.
  always_comb begin
    shifted  = {part_rem, next_bit};
    diff     = shifted[M:0] - {1'b0, divisor_mag};
    q_bit    = (shifted >= {2'b00, divisor_mag});
    next_rem = q_bit ? diff : shifted[M:0];
  end

endmodule

// File: rtl/seq_div.sv
// Radix-2 restoring divider, one quotient bit per cycle, with signed mode and
// valid/ready handshakes on both sides.
module seq_div
  import div_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int M = DEFAULT_M
) (
  input  logic         clock,
  input  logic         aclr_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  input  logic         signed_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int            CW    = $clog2(N);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [N-1:0]  MIN_N = {1'b1, {(N-1){1'b0}}};

  div_state_t    state;
  logic [CW-1:0] count;
  logic [N-1:0]  work;
  logic [M:0]    part_rem;
  logic [M-1:0]  dvs_mag;
  logic [M-1:0]  dvd_lo;
  logic          mode_q;
  logic          dvd_neg;
  logic          dvs_neg;
  logic          zero_q;
  logic          ovf_q;

  logic          dvd_sign;
  logic          dvs_sign;
  logic [N-1:0]  dvd_abs;
  logic [M-1:0]  dvs_abs;
  logic [M:0]    step_rem;
  logic          step_bit;
  logic [N-1:0]  quot_fix;
  logic [M-1:0]  rem_fix;

  // Operand magnitudes at accept time, and sign correction of the finished result.
  always_comb begin
    dvd_sign = signed_mode & dividend[N-1];
    dvs_sign = signed_mode & divisor[M-1];
    dvd_abs  = dvd_sign ? -dividend : dividend;
    dvs_abs  = dvs_sign ? -divisor : divisor;
    quot_fix = (mode_q & (dvd_neg ^ dvs_neg)) ? -work : work;
    rem_fix  = (mode_q & dvd_neg) ? -part_rem[M-1:0] : part_rem[M-1:0];
  end

  div_step #(
    .M(M)
  ) u_step (
    .part_rem    (part_rem),
    .next_bit    (work[N-1]),
    .divisor_mag (dvs_mag),
    .next_rem    (step_rem),
    .q_bit       (step_bit)
  );

  // The dividend magnitude shifts out of work's MSB while quotient bits shift into its LSB.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state       <= IDLE;
      count       <= '0;
      work        <= '0;
      part_rem    <= '0;
      dvs_mag     <= '0;
      dvd_lo      <= '0;
      mode_q      <= 1'b0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q   <= signed_mode;
            dvd_neg  <= dvd_sign;
            dvs_neg  <= dvs_sign;
            work     <= dvd_abs;
            dvs_mag  <= dvs_abs;
            dvd_lo   <= dividend[M-1:0];
            zero_q   <= (divisor == '0);
            ovf_q    <= signed_mode && (dividend == MIN_N) && (divisor == {M{1'b1}});
            part_rem <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          part_rem <= step_rem;
          work     <= {work[N-2:0], step_bit};
          if (count == LAST) begin
            count <= '0;
            state <= FIX;
          end else begin
            count <= count + CW'(1);
          end
        end
        FIX: begin
          state     <= DONE;
          out_valid <= 1'b1;
          if (zero_q) begin
            quotient    <= {N{DIV0_QUOT_BIT}};
            remainder   <= dvd_lo;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (ovf_q) begin
            quotient    <= MIN_N;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= quot_fix;
            remainder   <= rem_fix;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: arithmetic reference model, per-cycle compare
// process, directed corner cases and randomized operations.
module tb_seq_div;

  localparam int N   = 32;
  localparam int M   = 16;
  localparam int LAT = N + 2;

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  logic         clock       = 1'b0;
  logic         aclr_n      = 1'b1;
  logic         in_valid    = 1'b0;
  logic         signed_mode = 1'b0;
  logic         out_ready   = 1'b0;
  logic [N-1:0] dividend    = '0;
  logic [M-1:0] divisor     = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int compared   = 0;
  int mismatched = 0;

  seq_div #(
    .N(N),
    .M(M)
  ) dut (
    .clock       (clock),
    .aclr_n      (aclr_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truncated division straight from the arithmetic definition.
  function automatic res_t model(input logic [31:0] a, input logic [15:0] b, input logic sm);
    longint sa, sb, q, r;
    res_t   res;
    res = '0;
    if (b == 16'd0) begin
      res.q  = 32'hFFFF_FFFF;
      res.r  = a[15:0];
      res.dz = 1'b1;
    end else if (sm && a == 32'h8000_0000 && b == 16'hFFFF) begin
      res.q  = 32'h8000_0000;
      res.r  = 16'd0;
      res.ov = 1'b1;
    end else begin
      if (sm) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      q     = sa / sb;
      r     = sa % sb;
      res.q = q[31:0];
      res.r = r[15:0];
    end
    return res;
  endfunction

  // Accept-to-result timing, in_ready/out_valid and output stability, every cycle.
  logic busy    = 1'b0;
  int   cnt     = 0;
  res_t exp_cur = '0;
  res_t held    = '0;

  always @(negedge clock) begin
    if (!aclr_n) begin
      busy = 1'b0;
      cnt  = 0;
      held = '0;
      check_output("rst_in_ready", in_ready, 1);
      check_output("rst_out_valid", out_valid, 0);
    end else if (busy) begin
      cnt++;
      if (cnt == LAT) held = exp_cur;
      check_output("out_valid_timing", out_valid, (cnt >= LAT));
      check_output("in_ready_busy", in_ready, 0);
    end else begin
      check_output("out_valid_idle", out_valid, 0);
      check_output("in_ready_idle", in_ready, 1);
    end
    check_output("quotient", quotient, held.q);
    check_output("remainder", remainder, held.r);
    check_output("div_by_zero", div_by_zero, held.dz);
    check_output("overflow", overflow, held.ov);
    if (aclr_n) begin
      if (busy && cnt >= LAT && out_ready) begin
        busy = 1'b0;
      end else if (!busy && in_valid) begin
        busy    = 1'b1;
        cnt     = 0;
        exp_cur = model(dividend, divisor, signed_mode);
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] a, input logic [15:0] b, input logic sm);
    @(posedge clock); #1;
    in_valid    = 1'b1;
    dividend    = a;
    divisor     = b;
    signed_mode = sm;
    @(posedge clock); #1;
    in_valid    = 1'b0;
    dividend    = $urandom;
    divisor     = 16'($urandom);
    signed_mode = 1'($urandom);
  endtask

  task automatic wait_result(input bit noise, output res_t got);
    int i = 0;
    while (!out_valid && i < LAT + 10) begin
      if (noise) begin
        out_ready = 1'($urandom);
        in_valid  = 1'($urandom);
        dividend  = $urandom;
        divisor   = 16'($urandom);
      end
      @(posedge clock); #1;
      i++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (!out_valid) check_output("result_timeout", out_valid, 1);
    got.q  = quotient;
    got.r  = remainder;
    got.dz = div_by_zero;
    got.ov = overflow;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_directed(input string name, input logic [31:0] a, input logic [15:0] b,
                              input logic sm, input logic [31:0] eq, input logic [15:0] er,
                              input logic edz, input logic eov);
    res_t got;
    apply_stimulus(a, b, sm);
    wait_result(1'b0, got);
    check_output({name, "_q"}, got.q, eq);
    check_output({name, "_r"}, got.r, er);
    check_output({name, "_dz"}, got.dz, edz);
    check_output({name, "_ov"}, got.ov, eov);
    handoff();
  endtask

  initial begin
    res_t got;
    res_t pin;

    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_t got;
    res_t pin;

    aclr_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_quotient", quotient, 0);
    check_output("reset_remainder", remainder, 0);
    @(posedge clock); #1;
    aclr_n = 1'b1;

    pin = model(32'd100, 16'd7, 1'b0);
    check_output("model_u_q", pin.q, 32'd14);
    check_output("model_u_r", pin.r, 16'd2);
    pin = model(32'hFFFF_FF9C, 16'd7, 1'b1);
    check_output("model_s_q", pin.q, 32'hFFFF_FFF2);
    check_output("model_s_r", pin.r, 16'hFFFE);
    pin = model(32'h8000_0000, 16'hFFFF, 1'b0);
    check_output("model_umin_r", pin.r, 16'h8000);

    run_directed("u_100_7",     32'd100,       16'd7,    1'b0, 32'd14,        16'd2,    1'b0, 1'b0);
    run_directed("s_m100_7",    32'hFFFF_FF9C, 16'd7,    1'b1, 32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0);
    run_directed("s_100_m7",    32'd100,       16'hFFF9, 1'b1, 32'hFFFF_FFF2, 16'h0002, 1'b0, 1'b0);
    run_directed("s_ovf",       32'h8000_0000, 16'hFFFF, 1'b1, 32'h8000_0000, 16'h0000, 1'b0, 1'b1);
    run_directed("u_min_ffff",  32'h8000_0000, 16'hFFFF, 1'b0, 32'h0000_8000, 16'h8000, 1'b0, 1'b0);
    run_directed("u_div0",      32'h1234_5678, 16'h0000, 1'b0, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1'b0);
    run_directed("s_div0",      32'h1234_5678, 16'h0000, 1'b1, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1'b0);

    // Backpressure: a new request waits while the result is held.
    apply_stimulus(32'd1000, 16'd3, 1'b0);
    wait_result(1'b0, got);
    in_valid    = 1'b1;
    dividend    = 32'd5000;
    divisor     = 16'd9;
    signed_mode = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      check_output("bp_out_valid", out_valid, 1);
      check_output("bp_in_ready", in_ready, 0);
      check_output("bp_quotient", quotient, 32'd333);
      check_output("bp_remainder", remainder, 16'd1);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check_output("bp_release_in_ready", in_ready, 1);
    check_output("bp_release_out_valid", out_valid, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check_output("bp_accepted", in_ready, 0);
    wait_result(1'b0, got);
    check_output("bp_second_q", got.q, 32'd555);
    check_output("bp_second_r", got.r, 16'd5);
    handoff();

    // Abort in the tenth calculation cycle.
    apply_stimulus(32'hDEAD_BEEF, 16'h1234, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    aclr_n = 1'b0;
    #1;
    check_output("abort_out_valid", out_valid, 0);
    check_output("abort_in_ready", in_ready, 1);
    check_output("abort_quotient", quotient, 0);
    repeat (2) @(posedge clock);
    #1;
    aclr_n = 1'b1;
    run_directed("after_abort", 32'd65535, 16'd255, 1'b0, 32'd257, 16'd0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [15:0] b;
      logic        sm;
      int          sel;
      a   = $urandom;
      b   = 16'($urandom);
      sm  = 1'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 16'd0;
        1: begin a = 32'h8000_0000; b = 16'hFFFF; end
        2: b = 16'hFFFF;
        3: a = 32'h8000_0000;
        4: b = 16'($urandom_range(1, 15));
        5: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      apply_stimulus(a, b, sm);
      wait_result(1'b1, got);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
      end
      handoff();
    end

    repeat (3) @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
